planning_move_scheduler: RTL and testbench
==========================================

# planning_move_scheduler

Sequencing and arbitration controller for the grid-planning datapath. It moves the system through the phases init, obstacle warm-up, run and halt. It grants at most one mover per cycle (robot, obstacle 1, obstacle 2), which enforces the exclusive-move property by construction. It stops the run on collision, goal, or exhausted robot move budget. It sits between the move requesters and the grid/position block, and drives the grid's per-mover move strobes and direction.

## Interface
- WARMUP_MIN, 4: minimum warm-up cycles before end_init is honoured (≥1).
- MOVE_BUDGET, 16: maximum robot grants in RUN before timeout (1..255).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- end_init  in  1  level; request to leave warm-up.
- req  in  3  level move requests; bit0 robot, bit1 obs1, bit2 obs2.
- dir_robot, dir_obs1, dir_obs2  in  2 each  requested direction: 00 up, 01 down, 10 left, 11 right.
- collision  in  1  grid reports robot within collision zone of an obstacle.
- goal  in  1  grid reports robot at target.
- grant  out  3  one-hot move strobe (same bit order as req), registered.
- move_dir  out  2  direction of the granted mover, valid while grant≠0.
- phase  out  2  00 IDLE, 01 WARMUP, 10 RUN, 11 HALT.
- error  out  1  sticky, collision stop.
- done  out  1  sticky, goal reached.
- timeout  out  1  sticky, budget exhausted.

## Operation
- Phase FSM:
  - IDLE → WARMUP unconditionally on the first clock after reset. No grants in IDLE. The grid uses this cycle to load obstacle start positions.
  - WARMUP: only req[2:1] are eligible; req[0] is ignored. warm_cnt increments each cycle and saturates at WARMUP_MIN.
  - WARMUP → RUN on a cycle where end_init=1 and warm_cnt==WARMUP_MIN. end_init earlier than that is ignored, not queued.
  - RUN: all three requesters are eligible. Stop conditions are sampled each RUN cycle with priority collision > goal > budget:
    - collision=1 → HALT, error←1.
    - else goal=1 → HALT, done←1.
    - else robot grant count == MOVE_BUDGET with no goal → HALT, timeout←1.
  - Exactly one sticky flag is set per halt.
  - HALT: no grants, flags hold, until rst. collision/goal are ignored outside RUN.
- Arbitration is round-robin over indices 0,1,2:
  - Search starts at ptr+1 mod 3 and stops at the first eligible, unmasked request.
  - ptr updates to the granted index only when a grant issues.
  - Reset value of ptr is 2, so the robot is searched first.
- Handshake:
  - Requesters hold req and dir stable until they see their grant bit.
  - The grant cycle consumes the request.
  - The requester granted in cycle n is masked from the arbitration performed in cycle n. This prevents a duplicate grant from a still-high req; it may win again from cycle n+1 on.
- move_dir is the latched dir of the winner. When grant=000 it is 00.
- Robot budget counter:
  - 8-bit, counts robot grants issued in RUN.
  - Compared against MOVE_BUDGET after the increment.
  - The final budgeted move still issues; HALT takes effect the following cycle.
- A grant is never issued in the cycle the FSM enters HALT. A RUN-cycle stop condition suppresses that cycle's arbitration.

## Timing
- All outputs are registered.
- Reset values: grant=000, move_dir=00, phase=00, error=done=timeout=0, ptr=2, warm_cnt=0, budget count=0.
- Arbitration latency: req/dir sampled at edge n gives grant at edge n+1, held exactly one cycle.
- Maximum grant rate is one per cycle. With two or more continuous requesters, each is served at least once every 3 cycles.
- Flags and phase change at the same edge. Stop inputs sampled at edge n give phase=11 after edge n. A grant already registered for the cycle before that edge still completes.
- rst asserted mid-RUN or mid-grant clears grant and all state immediately (asynchronously). After deassertion the sequence restarts at IDLE.

## Test plan
- Warm-up gating:
  - Stimulus: rst release; req=111 held; end_init=1 from first cycle; WARMUP_MIN=4.
  - Response: phase 00→01; grants alternate 010,100 for 4 cycles; grant[0] never set; phase=10 exactly at the 4th warm-up edge with end_init high.
- Round-robin fairness:
  - Stimulus: in RUN, req=111 held, dirs 00/01/10.
  - Response: grant sequence 001,010,100,001… with move_dir 00,01,10,00…; no back-to-back grant to the same requester.
- Single-requester repeat:
  - Stimulus: in RUN, req=001 only, held.
  - Response: grant 001 on alternate cycles (mask) or consecutive cycles per the mask rule, i.e. 001,000,001…; budget count increments per grant.
- Stop priority:
  - Stimulus: collision and goal both asserted in the same RUN cycle.
  - Response: phase=11, error=1, done=0, no further grants for 20 cycles.
- Budget timeout:
  - Stimulus: MOVE_BUDGET=3, robot-only requests, goal=0.
  - Response: 3 robot grants, then phase=11, timeout=1, no 4th grant.
- Async reset mid-grant:
  - Stimulus: rst pulse asserted during a cycle with grant=010.
  - Response: grant=000 and phase=00 immediately; after release, IDLE→WARMUP and warm_cnt restarts from 0.

Source files
------------

// File: rtl/planning_move_scheduler.sv
// planning_move_scheduler: phase FSM (IDLE/WARMUP/RUN/HALT) with one-grant-per-cycle round-robin mover arbiter; in: clk, rst, end_init, req, dir_*, collision, goal; out: grant, move_dir, phase, error, done, timeout
module planning_move_scheduler #(
  parameter int WARMUP_MIN  = 4,
  parameter int MOVE_BUDGET = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       end_init,
  input  logic [2:0] req,
  input  logic [1:0] dir_robot,
  input  logic [1:0] dir_obs1,
  input  logic [1:0] dir_obs2,
  input  logic       collision,
  input  logic       goal,
  output logic [2:0] grant,
  output logic [1:0] move_dir,
  output logic [1:0] phase,
  output logic       error,
  output logic       done,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, WARMUP, RUN, HALT} phase_t;
  localparam int WW = $clog2(WARMUP_MIN + 1);
  localparam logic [WW-1:0] W_MAX = WW'(WARMUP_MIN);
  localparam logic [7:0] B_MAX = 8'(MOVE_BUDGET);
  phase_t r_phase;
  logic [WW-1:0] r_warm_cnt;
  logic [7:0] r_bcnt;
  logic [1:0] r_ptr;
  logic [1:0] r_move_dir;
  logic [2:0] r_grant;
  logic r_error;
  logic r_done;
  logic r_timeout;
  logic [WW-1:0] w_warm_nxt;
  logic w_stop;
  logic w_any;
  logic [2:0] w_elig;
  logic [2:0] w_gnt;
  logic [1:0] w_c1;
  logic [1:0] w_c2;
  logic [1:0] w_win;
  logic [1:0] w_dir;
  always_comb begin
    w_warm_nxt = (r_warm_cnt == W_MAX) ? r_warm_cnt : r_warm_cnt + WW'(1);
    w_stop = (r_phase == RUN) && (collision || goal || r_bcnt == B_MAX);
    w_elig = ((r_phase == RUN && !w_stop) ? 3'b111 : (r_phase == WARMUP) ? 3'b110 : 3'b000) & req & ~r_grant;
    w_c1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_c2 = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    w_any = |w_elig;
    w_win = w_elig[w_c1] ? w_c1 : w_elig[w_c2] ? w_c2 : r_ptr;
    w_gnt = w_any ? 3'b001 << w_win : 3'b000;
    w_dir = !w_any ? 2'b00 : (w_win == 2'd0) ? dir_robot : (w_win == 2'd1) ? dir_obs1 : dir_obs2;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= IDLE;
      r_warm_cnt <= '0;
      r_bcnt <= '0;
      r_ptr <= 2'd2;
      r_grant <= '0;
      r_move_dir <= '0;
      r_error <= 1'b0;
      r_done <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_grant <= w_gnt;
      r_move_dir <= w_dir;
      if (w_any) r_ptr <= w_win;
      if (w_gnt[0]) r_bcnt <= r_bcnt + 8'd1;
      case (r_phase)
        IDLE: r_phase <= WARMUP;
        WARMUP: begin
          r_warm_cnt <= w_warm_nxt;
          if (end_init && w_warm_nxt == W_MAX) r_phase <= RUN;
        end
        RUN: if (w_stop) begin
          r_phase <= HALT;
          r_error <= collision;
          r_done <= !collision && goal;
          r_timeout <= !collision && !goal;
        end
        default: ;
      endcase
    end
  end
  assign grant = r_grant;
  assign move_dir = r_move_dir;
  assign phase = r_phase;
  assign error = r_error;
  assign done = r_done;
  assign timeout = r_timeout;
endmodule

// File: tb/tb_planning_move_scheduler.sv
// tb_planning_move_scheduler: directed scoreboard bench for a default instance and a MOVE_BUDGET=3 instance
module tb_planning_move_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic end_init = 1'b0;
  logic collision = 1'b0;
  logic goal = 1'b0;
  logic [2:0] req_a = '0;
  logic [2:0] req_b = '0;
  logic [1:0] d_r = 2'b00;
  logic [1:0] d_1 = 2'b01;
  logic [1:0] d_2 = 2'b10;
  logic [2:0] grant_a, grant_b;
  logic [1:0] dir_a, dir_b, ph_a, ph_b;
  logic err_a, err_b, done_a, done_b, to_a, to_b;
  logic [9:0] obs_a, obs_b;
  logic [19:0] sb[$];
  int vectors = 0;
  int miscompares = 0;
  localparam logic [9:0] Z  = 10'b000_00_00_000;
  localparam logic [9:0] W  = 10'b000_00_01_000;
  localparam logic [9:0] R  = 10'b000_00_10_000;
  localparam logic [9:0] HE = 10'b000_00_11_100;
  localparam logic [9:0] HD = 10'b000_00_11_010;
  localparam logic [9:0] HT = 10'b000_00_11_001;
  planning_move_scheduler dut_a (
    .clk(clk), .rst(rst), .end_init(end_init), .req(req_a),
    .dir_robot(d_r), .dir_obs1(d_1), .dir_obs2(d_2),
    .collision(collision), .goal(goal),
    .grant(grant_a), .move_dir(dir_a), .phase(ph_a),
    .error(err_a), .done(done_a), .timeout(to_a)
  );
  planning_move_scheduler #(.WARMUP_MIN(4), .MOVE_BUDGET(3)) dut_b (
    .clk(clk), .rst(rst), .end_init(end_init), .req(req_b),
    .dir_robot(d_r), .dir_obs1(d_1), .dir_obs2(d_2),
    .collision(collision), .goal(goal),
    .grant(grant_b), .move_dir(dir_b), .phase(ph_b),
    .error(err_b), .done(done_b), .timeout(to_b)
  );
  assign obs_a = {grant_a, dir_a, ph_a, err_a, done_a, to_a};
  assign obs_b = {grant_b, dir_b, ph_b, err_b, done_b, to_b};
  always #5 clk = ~clk;
  function automatic logic [9:0] v(input logic [2:0] g, input logic [1:0] d, input logic [1:0] p);
    return {g, d, p, 3'b000};
  endfunction
  task automatic check(input string tag);
    logic [19:0] e;
    e = sb.pop_front();
    vectors++;
    assert ({obs_a, obs_b} === e) else begin
      miscompares++;
      $error("FAIL %s: observed a=%b b=%b expected a=%b b=%b", tag, obs_a, obs_b, e[19:10], e[9:0]);
    end
  endtask
  task automatic cyc(input string tag, input logic [9:0] ea, input logic [9:0] eb);
    sb.push_back({ea, eb});
    @(posedge clk);
    #1;
    check(tag);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    sb.push_back({Z, Z});
    check("reset");
    rst = 1'b0;
    req_a = 3'b111;
    end_init = 1'b1;
    cyc("idle_to_warm", W, W);
    cyc("warm_g1", v(3'b010, 2'b01, 2'b01), W);
    cyc("warm_g2", v(3'b100, 2'b10, 2'b01), W);
    cyc("warm_g3", v(3'b010, 2'b01, 2'b01), W);
    cyc("warm_to_run", v(3'b100, 2'b10, 2'b10), R);
    cyc("rr_1", v(3'b001, 2'b00, 2'b10), R);
    cyc("rr_2", v(3'b010, 2'b01, 2'b10), R);
    cyc("rr_3", v(3'b100, 2'b10, 2'b10), R);
    cyc("rr_4", v(3'b001, 2'b00, 2'b10), R);
    cyc("rr_5", v(3'b010, 2'b01, 2'b10), R);
    cyc("rr_6", v(3'b100, 2'b10, 2'b10), R);
    req_a = 3'b001;
    cyc("single_1", v(3'b001, 2'b00, 2'b10), R);
    cyc("single_mask", R, R);
    cyc("single_2", v(3'b001, 2'b00, 2'b10), R);
    cyc("single_mask2", R, R);
    collision = 1'b1;
    goal = 1'b1;
    cyc("stop_prio", HE, HE);
    req_a = 3'b111;
    req_b = 3'b111;
    for (int i = 0; i < 20; i++) begin
      collision = 1'($urandom_range(0, 1));
      goal = 1'($urandom_range(0, 1));
      cyc("halt_hold", HE, HE);
    end
    rst = 1'b1;
    #1;
    sb.push_back({Z, Z});
    check("async_rst_halt");
    @(posedge clk);
    #1;
    rst = 1'b0;
    collision = 1'b0;
    goal = 1'b0;
    req_a = 3'b111;
    req_b = 3'b001;
    cyc("r2_warm", W, W);
    cyc("r2_grant", v(3'b010, 2'b01, 2'b01), W);
    #3;
    rst = 1'b1;
    #1;
    sb.push_back({Z, Z});
    check("async_rst_grant");
    #2;
    rst = 1'b0;
    cyc("r3_warm", W, W);
    cyc("r3_g1", v(3'b010, 2'b01, 2'b01), W);
    cyc("r3_g2", v(3'b100, 2'b10, 2'b01), W);
    cyc("r3_g3", v(3'b010, 2'b01, 2'b01), W);
    cyc("r3_run", v(3'b100, 2'b10, 2'b10), R);
    cyc("bud_1", v(3'b001, 2'b00, 2'b10), v(3'b001, 2'b00, 2'b10));
    cyc("bud_m1", v(3'b010, 2'b01, 2'b10), R);
    cyc("bud_2", v(3'b100, 2'b10, 2'b10), v(3'b001, 2'b00, 2'b10));
    cyc("bud_m2", v(3'b001, 2'b00, 2'b10), R);
    cyc("bud_3", v(3'b010, 2'b01, 2'b10), v(3'b001, 2'b00, 2'b10));
    cyc("bud_timeout", v(3'b100, 2'b10, 2'b10), HT);
    goal = 1'b1;
    cyc("goal_stop", HD, HT);
    goal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      collision = 1'(i & 1);
      cyc("post_halt", HD, HT);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
